// File: rtl/deser8_pkg.sv
// Shared constants and types for the deser8_demux serial-to-parallel receiver.
package deser8_pkg;

  localparam int unsigned DESER_W = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [0:0] {S_COLLECT, S_PARITY} state_e;

  localparam logic [DESER_W-1:0] OUT_BYTE_RST = '0;
  localparam logic [IDX_W-1:0]   IDX_RST      = '0;
  localparam logic [IDX_W-1:0]   IDX_LAST     = IDX_W'(DESER_W - 1);

endpackage

// File: rtl/deser8_demux_if.sv
// Bit-stream input and byte-output handshake bundle for deser8_demux.
interface deser8_demux_if;
  import deser8_pkg::*;

  logic               in_valid;
  logic               in_bit;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [DESER_W-1:0] out_byte;
  logic               parity_err;

  // master drives bits and consumes bytes; slave is the deserializer
  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_byte, parity_err
  );

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_byte, parity_err
  );
endinterface

// File: rtl/bit_demux8.sv
// 3-to-8 one-hot decoder with enable: shadow-register write enables, the
// structural inverse of the 8:1 bit-select mux.
module bit_demux8
  import deser8_pkg::*;
(
  input  logic               en_i,
  input  logic [IDX_W-1:0]   sel_i,
  output logic [DESER_W-1:0] we_o
);

  always_comb begin
    we_o = '0;
    if (en_i) begin
      we_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/deser8_demux.sv
// Serial-to-parallel receiver: LSB-first bits into a one-entry byte buffer.
// Define DESER8_PARITY_EN for 9-bit frames with a trailing even-parity bit.
module deser8_demux
  import deser8_pkg::*;
#(
  parameter int unsigned WIDTH = DESER_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  deser8_demux_if.slave  bus
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   shadow_q, shadow_d;
  logic [DESER_W-1:0] out_byte_q, out_byte_d;
  logic               out_valid_q, out_valid_d;
`ifdef DESER8_PARITY_EN
  logic               perr_q, perr_d;
`endif

  logic               in_ready;
  logic               stall_pos;
  logic               accept;
  logic               demux_en;
  logic [WIDTH-1:0]   we;

  assign accept   = bus.in_valid && in_ready;
  assign demux_en = accept && !clear && (state_q == S_COLLECT);

  bit_demux8 u_bit_demux8 (
    .en_i  (demux_en),
    .sel_i (idx_q),
    .we_o  (we)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_COLLECT;
      idx_q       <= IDX_RST;
      shadow_q    <= '0;
      out_byte_q  <= OUT_BYTE_RST;
      out_valid_q <= 1'b0;
`ifdef DESER8_PARITY_EN
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
`ifdef DESER8_PARITY_EN
      perr_q      <= perr_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    out_byte_d  = out_byte_q;
    out_valid_d = out_valid_q;
`ifdef DESER8_PARITY_EN
    perr_d      = perr_q;
`endif

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // clear wins over a same-cycle accept; the output buffer keeps draining
    if (clear) begin
      state_d  = S_COLLECT;
      idx_d    = IDX_RST;
      shadow_d = '0;
    end else if (accept) begin
`ifdef DESER8_PARITY_EN
      if (state_q == S_PARITY) begin
        out_byte_d  = shadow_q;
        perr_d      = ^shadow_q ^ bus.in_bit;
        out_valid_d = 1'b1;
        shadow_d    = '0;
        state_d     = S_COLLECT;
      end else begin
        shadow_d = (shadow_q & ~we) | (we & {WIDTH{bus.in_bit}});
        idx_d    = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = S_PARITY;
        end
      end
`else
      shadow_d = (shadow_q & ~we) | (we & {WIDTH{bus.in_bit}});
      idx_d    = idx_q + 1'b1;
      if (idx_q == IDX_LAST) begin
        out_byte_d  = {bus.in_bit, shadow_q[DESER_W-2:0]};
        out_valid_d = 1'b1;
        shadow_d    = '0;
      end
`endif
    end
  end

  // Outputs: only the frame-closing bit can stall, and only if the buffer cannot drain
  always_comb begin
`ifdef DESER8_PARITY_EN
    stall_pos = (state_q == S_PARITY);
`else
    stall_pos = (idx_q == IDX_LAST);
`endif
    in_ready = reset && !(stall_pos && out_valid_q && !bus.out_ready);
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_byte  = out_byte_q;
`ifdef DESER8_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_deser8_demux.sv
// Table-driven bench for deser8_demux plus hand-written frame sequences;
// follows DESER8_PARITY_EN when defined.
module tb_deser8_demux;

  typedef struct {
    logic       rst;
    logic       clr;
    logic       iv;
    logic       ib;
    logic       ordy;
    logic       eir;
    logic       eov;
    logic [7:0] eob;
    logic       eperr;
    logic       chk;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;

  deser8_demux_if bus ();

  deser8_demux #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  vec_t tbl[$];

  task automatic add(input logic rst, input logic clr, input logic iv, input logic ib,
                     input logic ordy, input logic eir, input logic eov,
                     input logic [7:0] eob, input logic eperr, input logic chk);
    vec_t v;
    v.rst = rst; v.clr = clr; v.iv = iv; v.ib = ib; v.ordy = ordy;
    v.eir = eir; v.eov = eov; v.eob = eob; v.eperr = eperr; v.chk = chk;
    tbl.push_back(v);
  endtask

  // n bits of b, LSB first, each expected to be accepted
  task automatic add_bits(input logic [7:0] b, input int n, input logic ordy,
                          input logic eov, input logic [7:0] eob, input logic eperr);
    for (int i = 0; i < n; i++) begin
      add(1'b1, 1'b0, 1'b1, b[i], ordy, 1'b1, eov, eob, eperr, 1'b1);
    end
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b);
    logic [8:0] bits;
    int         nb;
    int         n;
    bits = {^b, b};
`ifdef DESER8_PARITY_EN
    nb = 9;
`else
    nb = 8;
`endif
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_bit   = bits[i];
      #1;
      n = 0;
      while (!bus.in_ready && n < 20) begin
        @(negedge clk);
        #1;
        n++;
      end
      check($sformatf("hs bit%0d in_ready", i), {7'b0, bus.in_ready}, 8'h01);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_byte(input logic [7:0] b);
    int n;
    #1;
    n = 0;
    while (!bus.out_valid && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("hs out_valid", {7'b0, bus.out_valid}, 8'h01);
    check("hs out_byte", bus.out_byte, b);
    check("hs parity_err", {7'b0, bus.parity_err}, 8'h00);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.out_ready = 1'b0;

    // reset two cycles, then first high cycle
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
`ifdef DESER8_PARITY_EN
    add_bits(8'h07, 8, 1'b1, 1'b0, 8'h00, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1);
    add_bits(8'h07, 8, 1'b1, 1'b0, 8'h07, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h07, 1'b1, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h07, 1'b1, 1'b1);
`else
    // 0xA5 back-to-back, visible one cycle after the 8th accept, then drained
    add_bits(8'hA5, 8, 1'b1, 1'b0, 8'h00, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1);
    // 0x3C held, 0xFF stalls on its last bit until the buffer drains
    add_bits(8'h3C, 8, 1'b0, 1'b0, 8'hA5, 1'b0);
    add_bits(8'hFF, 7, 1'b0, 1'b1, 8'h3C, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1);
    // 3 bits, clear with a dropped bit, then 0x81
    add_bits(8'h07, 3, 1'b1, 1'b0, 8'hFF, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1);
    add_bits(8'h81, 8, 1'b1, 1'b0, 8'hFF, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h81, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1);
    // 0x55 buffered, 5 bits in, reset, then a clean 0x96
    add_bits(8'h55, 8, 1'b0, 1'b0, 8'h81, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b1);
    add_bits(8'h1F, 5, 1'b0, 1'b1, 8'h55, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    add_bits(8'h96, 8, 1'b1, 1'b0, 8'h00, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h96, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h96, 1'b0, 1'b1);
`endif

    foreach (tbl[i]) begin
      @(negedge clk);
      reset         = tbl[i].rst;
      clear         = tbl[i].clr;
      bus.in_valid  = tbl[i].iv;
      bus.in_bit    = tbl[i].ib;
      bus.out_ready = tbl[i].ordy;
      #1;
      check($sformatf("v%0d in_ready", i), {7'b0, bus.in_ready}, {7'b0, tbl[i].eir});
      if (tbl[i].chk) begin
        check($sformatf("v%0d out_valid", i), {7'b0, bus.out_valid}, {7'b0, tbl[i].eov});
        check($sformatf("v%0d out_byte", i), bus.out_byte, tbl[i].eob);
        check($sformatf("v%0d parity_err", i), {7'b0, bus.parity_err}, {7'b0, tbl[i].eperr});
      end
    end

    // hand-driven frames through the handshake with bounded waits
    @(negedge clk);
    reset         = 1'b1;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    send_frame(8'hC3);
    expect_byte(8'hC3);
    send_frame(8'h5A);
    expect_byte(8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
